// File: rtl/ball_controller.sv
// Pong ball/score engine: step_en-paced motion with wall and paddle bounces, scoring and game sequencing.
// All outputs are registered; a step_en pulse is reflected on the outputs one cycle later.
module ball_controller #(
    parameter int DISP_COLS   = 800,
    parameter int DISP_ROWS   = 600,
    parameter int BALL_HALF   = 4,
    parameter int PADDLE_HALF = 40,
    parameter int L_FACE_COL  = 24,
    parameter int R_FACE_COL  = 775,
    parameter int HOLD_STEPS  = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic        serve,
    input  logic [11:0] l_paddle_row,
    input  logic [11:0] r_paddle_row,
    output logic [11:0] ball_center_col,
    output logic [11:0] ball_center_row,
    output logic [1:0]  ball_direction,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [2:0]  state,
    output logic        point
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_POINT = 3'd2,
        S_OVER  = 3'd3
    } state_e;

    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [11:0]       CEN_C     = 12'(DISP_COLS / 2);
    localparam logic [11:0]       CEN_R     = 12'(DISP_ROWS / 2);
    localparam logic [11:0]       BH_U      = 12'(BALL_HALF);
    localparam logic [11:0]       BOT_ROW   = 12'(DISP_ROWS - 1 - BALL_HALF);
    localparam logic [11:0]       R_MISS    = 12'(DISP_COLS - 1 - BALL_HALF);
    localparam logic signed [12:0] BH_S     = 13'(BALL_HALF);
    localparam logic signed [12:0] LF_S     = 13'(L_FACE_COL);
    localparam logic signed [12:0] RF_S     = 13'(R_FACE_COL);
    localparam logic signed [12:0] REACH    = 13'(PADDLE_HALF + BALL_HALF);
    localparam logic [3:0]        WIN4      = 4'(WIN_SCORE);

    // direction bit 1 = moving right, bit 0 = moving down
    state_e         state_q, state_d;
    logic [11:0]    col_q, col_d, row_q, row_d;
    logic [1:0]     dir_q, dir_d;
    logic [3:0]     sl_q, sl_d, sr_q, sr_d;
    logic           point_q, point_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic signed [12:0] col_s, row_s, dl, dr, adl, adr;
    logic               hright, vdown;

    always_comb begin
        col_s = $signed({1'b0, col_q});
        row_s = $signed({1'b0, row_q});
        dl    = row_s - $signed({1'b0, l_paddle_row});
        dr    = row_s - $signed({1'b0, r_paddle_row});
        adl   = (dl < 0) ? -dl : dl;
        adr   = (dr < 0) ? -dr : dr;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dir_d   = dir_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        point_d = 1'b0;
        hold_d  = hold_q;
        hright  = dir_q[1];
        vdown   = dir_q[0];
        case (state_q)
            S_IDLE: begin
                col_d = CEN_C;
                row_d = CEN_R;
                if (serve) state_d = S_PLAY;
            end
            S_PLAY: if (step_en) begin
                // a miss freezes the ball where it is and beats any bounce
                if (!dir_q[1] && col_q <= BH_U) begin
                    sr_d    = (sr_q < WIN4) ? sr_q + 4'd1 : sr_q;
                    point_d = 1'b1;
                    hold_d  = '0;
                    state_d = S_POINT;
                end else if (dir_q[1] && col_q >= R_MISS) begin
                    sl_d    = (sl_q < WIN4) ? sl_q + 4'd1 : sl_q;
                    point_d = 1'b1;
                    hold_d  = '0;
                    state_d = S_POINT;
                end else begin
                    if (!dir_q[0] && row_q <= BH_U)        vdown = 1'b1;
                    else if (dir_q[0] && row_q >= BOT_ROW) vdown = 1'b0;
                    if (!dir_q[1] && (col_s - BH_S) <= LF_S && adl <= REACH)     hright = 1'b1;
                    else if (dir_q[1] && (col_s + BH_S) >= RF_S && adr <= REACH) hright = 1'b0;
                    dir_d = {hright, vdown};
                    col_d = hright ? col_q + 12'd1 : col_q - 12'd1;
                    row_d = vdown  ? row_q + 12'd1 : row_q - 12'd1;
                end
            end
            S_POINT: if (step_en) begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (sl_q == WIN4 || sr_q == WIN4) begin
                        state_d = S_OVER;
                    end else begin
                        // horizontal bit still points at the side that conceded
                        col_d   = CEN_C;
                        row_d   = CEN_R;
                        dir_d   = {dir_q[1], 1'b1};
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_OVER: if (serve) begin
                sl_d    = 4'd0;
                sr_d    = 4'd0;
                col_d   = CEN_C;
                row_d   = CEN_R;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= CEN_C;
            row_q   <= CEN_R;
            dir_q   <= 2'b11;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
            point_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dir_q   <= dir_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            point_q <= point_d;
            hold_q  <= hold_d;
        end
    end

    assign ball_center_col = col_q;
    assign ball_center_row = row_q;
    assign ball_direction  = dir_q;
    assign score_l         = sl_q;
    assign score_r         = sr_q;
    assign state           = state_q;
    assign point           = point_q;

endmodule

// File: tb/tb_ball_controller.sv
// Bench for ball_controller: directed scenarios plus random play against a behavioural game model.
module tb_ball_controller;
    localparam int COLS = 800, ROWS = 600, BH = 4, PH = 40, LF = 24, RF = 775;
    localparam int HOLD = 60, WIN = 9;
    localparam int PH_IDLE = 0, PH_PLAY = 1, PH_POINT = 2, PH_OVER = 3;
    localparam logic [37:0] RESET_VEC = {12'd400, 12'd300, 2'b11, 4'd0, 4'd0, 3'd0, 1'b0};

    logic        clk = 1'b0;
    logic        rst, step_en, serve;
    logic [11:0] l_paddle_row, r_paddle_row;
    logic [11:0] ball_center_col, ball_center_row;
    logic [1:0]  ball_direction;
    logic [3:0]  score_l, score_r;
    logic [2:0]  state;
    logic        point;

    int n_checks = 0, n_fail = 0;
    int m_col, m_row, m_dx, m_dy, m_sl, m_sr, m_phase, m_hold, m_point;
    bit m_left_conceded;

    ball_controller dut (
        .clk(clk), .rst(rst), .step_en(step_en), .serve(serve),
        .l_paddle_row(l_paddle_row), .r_paddle_row(r_paddle_row),
        .ball_center_col(ball_center_col), .ball_center_row(ball_center_row),
        .ball_direction(ball_direction), .score_l(score_l), .score_r(score_r),
        .state(state), .point(point)
    );

    always #5 clk = ~clk;

    logic [37:0] dut_vec;
    assign dut_vec = {ball_center_col, ball_center_row, ball_direction, score_l, score_r, state, point};

    function automatic logic [37:0] exp_vec();
        return {12'(m_col), 12'(m_row), (m_dx > 0), (m_dy > 0), 4'(m_sl), 4'(m_sr), 3'(m_phase), 1'(m_point)};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // paddle placement: 0 on the ball, 1 far away, 2 anywhere, 3 near the reach limit
    function automatic int pad(input int mode);
        int p;
        case (mode)
            0: p = m_row;
            1: p = 4000;
            2: p = int'($urandom_range(0, ROWS - 1));
            default: p = m_row + int'($urandom_range(0, 100)) - 50;
        endcase
        return (p < 0) ? 0 : p;
    endfunction

    task automatic model_reset();
        m_col = COLS / 2; m_row = ROWS / 2; m_dx = 1; m_dy = 1;
        m_sl = 0; m_sr = 0; m_phase = PH_IDLE; m_hold = 0; m_point = 0;
        m_left_conceded = 1'b0;
    endtask

    // drive one clock of inputs and advance the game model by the same rules
    task automatic cycle(input bit sv, input bit st, input int lmode, input int rmode);
        int lp, rp;
        serve = sv; step_en = st;
        l_paddle_row = 12'(pad(lmode));
        r_paddle_row = 12'(pad(rmode));
        lp = int'(l_paddle_row);
        rp = int'(r_paddle_row);
        m_point = 0;
        case (m_phase)
            PH_IDLE: if (sv) m_phase = PH_PLAY;
            PH_PLAY: if (st) begin
                if (m_dx < 0 && m_col <= BH) begin
                    m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
                    m_point = 1; m_phase = PH_POINT; m_hold = 0; m_left_conceded = 1'b1;
                end else if (m_dx > 0 && m_col >= COLS - 1 - BH) begin
                    m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
                    m_point = 1; m_phase = PH_POINT; m_hold = 0; m_left_conceded = 1'b0;
                end else begin
                    if (m_dy < 0 && m_row <= BH) m_dy = 1;
                    else if (m_dy > 0 && m_row >= ROWS - 1 - BH) m_dy = -1;
                    if (m_dx < 0 && m_col - BH <= LF && iabs(m_row - lp) <= PH + BH) m_dx = 1;
                    else if (m_dx > 0 && m_col + BH >= RF && iabs(m_row - rp) <= PH + BH) m_dx = -1;
                    m_col += m_dx; m_row += m_dy;
                end
            end
            PH_POINT: if (st) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    if (m_sl == WIN || m_sr == WIN) m_phase = PH_OVER;
                    else begin
                        m_col = COLS / 2; m_row = ROWS / 2;
                        m_dx = m_left_conceded ? -1 : 1; m_dy = 1;
                        m_phase = PH_IDLE;
                    end
                end
            end
            default: if (sv) begin
                m_sl = 0; m_sr = 0; m_col = COLS / 2; m_row = ROWS / 2; m_phase = PH_IDLE;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; serve = 1'b0; step_en = 1'b0; l_paddle_row = '0; r_paddle_row = '0;
        model_reset();
        #2;
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec, RESET_VEC);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_serve_motion();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 2, 2);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL idle_ignores_step: got %h want %h", dut_vec, exp_vec());
            end
        end
        cycle(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 0, 0);
        n_checks++;
        if (dut_vec !== {12'd410, 12'd310, 2'b11, 4'd0, 4'd0, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL serve_ten_steps: got %h want %h", dut_vec,
                               {12'd410, 12'd310, 2'b11, 4'd0, 4'd0, 3'd1, 1'b0});
        end
    endtask

    task automatic test_point_hold();
        int pulses = 0;
        rst = 1'b1; model_reset(); #2; @(posedge clk); #1; rst = 1'b0;
        cycle(1'b1, 1'b0, 1, 0);
        for (int i = 0; i < 3000 && m_phase == PH_PLAY; i++) begin
            cycle(1'b0, 1'b1, 1, 0);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL rally_to_left_miss: got %h want %h", dut_vec, exp_vec());
            end
            if (point) pulses++;
        end
        n_checks++;
        if (state !== 3'd2 || score_r !== 4'd1) begin
            n_fail++; $display("FAIL left_miss_scores: got state %0d score_r %0d want 2 1", state, score_r);
        end
        for (int i = 0; i < HOLD - 1; i++) begin
            cycle(i % 7 == 0, 1'b1, 2, 2);
            if (point) pulses++;
        end
        n_checks++;
        if (state !== 3'd2) begin
            n_fail++; $display("FAIL hold_not_done: got state %0d want 2", state);
        end
        cycle(1'b0, 1'b1, 2, 2);
        n_checks++;
        if (dut_vec !== {12'd400, 12'd300, 2'b01, 4'd0, 4'd1, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL hold_exit_recentre: got %h want %h", dut_vec,
                               {12'd400, 12'd300, 2'b01, 4'd0, 4'd1, 3'd0, 1'b0});
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL point_pulse_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid_hold();
        cycle(1'b1, 1'b0, 1, 0);
        for (int i = 0; i < 3000 && m_phase == PH_PLAY; i++) cycle(1'b0, 1'b1, 1, 0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 2, 2);
        n_checks++;
        if (dut_vec !== exp_vec() || score_r !== 4'd2) begin
            n_fail++; $display("FAIL before_mid_hold_reset: got %h want %h", dut_vec, exp_vec());
        end
        rst = 1'b1; model_reset(); #2;
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL mid_hold_reset: got %h want %h", dut_vec, RESET_VEC);
        end
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 2, 2);
            n_checks++;
            if (dut_vec !== RESET_VEC) begin
                n_fail++; $display("FAIL no_motion_after_reset: got %h want %h", dut_vec, RESET_VEC);
            end
        end
    endtask

    task automatic test_game_over();
        for (int p = 1; p <= WIN; p++) begin
            cycle(1'b1, 1'b0, 0, 1);
            for (int i = 0; i < 3000 && m_phase == PH_PLAY; i++) cycle(1'b0, 1'b1, 0, 1);
            n_checks++;
            if (score_l !== 4'(p) || state !== 3'd2) begin
                n_fail++; $display("FAIL right_miss_%0d: got score_l %0d state %0d want %0d 2", p, score_l, state, p);
            end
            for (int i = 0; i < HOLD; i++) begin
                cycle(1'b0, 1'b1, 2, 2);
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL hold_after_point_%0d: got %h want %h", p, dut_vec, exp_vec());
                end
            end
        end
        n_checks++;
        if (state !== 3'd3 || score_l !== 4'd9) begin
            n_fail++; $display("FAIL game_over_entry: got state %0d score_l %0d want 3 9", state, score_l);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 2, 2);
        n_checks++;
        if (dut_vec !== exp_vec() || state !== 3'd3) begin
            n_fail++; $display("FAIL game_over_frozen: got %h want %h", dut_vec, exp_vec());
        end
        cycle(1'b1, 1'b0, 2, 2);
        n_checks++;
        if (dut_vec !== exp_vec() || state !== 3'd0 || score_l !== 4'd0 || score_r !== 4'd0) begin
            n_fail++; $display("FAIL game_over_serve: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random_play();
        int lmode = 0, rmode = 0;
        rst = 1'b1; model_reset(); #2; @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if (i % 250 == 0) begin
                lmode = int'($urandom_range(0, 3));
                rmode = int'($urandom_range(0, 3));
            end
            cycle($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, lmode, rmode);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_play cycle %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve_motion();
        test_point_hold();
        test_reset_mid_hold();
        test_game_over();
        test_random_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
